// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, minimum divisor and parity helper.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int MIN_DIV = 4;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;
`endif

  // Narrower words are zero-extended by the caller, which leaves parity unchanged.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
// Host-side bundle of the UART transceiver: divisor, TX/RX handshakes, serial pins, status.
interface uart_xcvr_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
);
  logic [DIV_W-1:0]     DIV;
  logic [DATA_BITS-1:0] TX_DATA;
  logic                 TX_VALID;
  logic                 TX_READY;
  logic                 TXD;
  logic                 RXD;
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_READY;
  logic                 RX_FERR;
  logic                 RX_PERR;
  logic                 RX_OVR;

  modport slave (
    input  DIV, TX_DATA, TX_VALID, RXD, RX_READY,
    output TX_READY, TXD, RX_DATA, RX_VALID, RX_FERR, RX_PERR, RX_OVR
  );

  modport master (
    output DIV, TX_DATA, TX_VALID, RXD, RX_READY,
    input  TX_READY, TXD, RX_DATA, RX_VALID, RX_FERR, RX_PERR, RX_OVR
  );
endinterface

// File: rtl/uart_bitcnt.sv
// Loadable bit-period down-counter; the first period after a load is either a full or a
// half divisor, later periods reload from the divisor latched at load time.
module uart_bitcnt
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             half,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] period_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg    <= DIV_W'(MIN_DIV - 1);
      period_reg <= DIV_W'(MIN_DIV);
    end else if (load) begin
      period_reg <= period;
      cnt_reg    <= (half ? (period >> 1) : period) - DIV_W'(1);
    end else if (cnt_reg == '0) begin
      cnt_reg <= period_reg - DIV_W'(1);
    end else begin
      cnt_reg <= cnt_reg - DIV_W'(1);
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with independent TX and RX FSMs sharing one divisor input.
// Optional parity bit generation/checking is compiled in with UART_PARITY_EN.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int PARITY_ODD = 0
) (
  input logic        CLK,
  input logic        RST,
  uart_xcvr_if.slave bus
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_xcvr: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_xcvr: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_xcvr: PARITY_ODD must be 0 or 1");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  uart_state_t          tx_state_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic [3:0]           tx_idx_reg;
  logic                 txd_reg;
  logic                 tx_ready_reg;
  logic                 tx_tick;
  logic                 tx_accept;
`ifdef UART_PARITY_EN
  logic                 tx_par_reg;
`endif

  assign tx_accept = tx_ready_reg && bus.TX_VALID;

  uart_bitcnt #(.DIV_W(DIV_W)) u_tx_cnt (
    .CLK, .RST, .load(tx_accept), .half(1'b0), .period(bus.DIV), .tick(tx_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_reg <= ST_IDLE;
      tx_shift_reg <= '0;
      tx_idx_reg   <= '0;
      txd_reg      <= 1'b1;
      tx_ready_reg <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_reg   <= 1'b0;
`endif
    end else begin
      case (tx_state_reg)
        ST_IDLE: if (tx_accept) begin
          tx_shift_reg <= bus.TX_DATA;
`ifdef UART_PARITY_EN
          tx_par_reg   <= uart_parity(8'(bus.TX_DATA), 1'(PARITY_ODD));
`endif
          txd_reg      <= 1'b0;
          tx_ready_reg <= 1'b0;
          tx_state_reg <= ST_START;
        end
        ST_START: if (tx_tick) begin
          txd_reg      <= tx_shift_reg[0];
          tx_shift_reg <= tx_shift_reg >> 1;
          tx_idx_reg   <= '0;
          tx_state_reg <= ST_DATA;
        end
        ST_DATA: if (tx_tick) begin
          if (tx_idx_reg == LAST_DATA) begin
`ifdef UART_PARITY_EN
            txd_reg      <= tx_par_reg;
            tx_state_reg <= ST_PARITY;
`else
            txd_reg      <= 1'b1;
            tx_idx_reg   <= '0;
            tx_state_reg <= ST_STOP;
`endif
          end else begin
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_idx_reg   <= tx_idx_reg + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: if (tx_tick) begin
          txd_reg      <= 1'b1;
          tx_idx_reg   <= '0;
          tx_state_reg <= ST_STOP;
        end
`endif
        ST_STOP: if (tx_tick) begin
          if (tx_idx_reg == LAST_STOP) begin
            tx_ready_reg <= 1'b1;
            tx_state_reg <= ST_IDLE;
          end else begin
            tx_idx_reg <= tx_idx_reg + 4'd1;
          end
        end
        default: begin
          txd_reg      <= 1'b1;
          tx_ready_reg <= 1'b1;
          tx_state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]           sync_reg;
  logic                 rx_prev_reg;
  logic                 rx_s;
  logic                 rx_start;
  logic                 rx_tick;
  uart_state_t          rx_state_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic [3:0]           rx_idx_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 rx_ferr_reg;
  logic                 rx_ovr_reg;
`ifdef UART_PARITY_EN
  logic                 rx_perr_reg;
  logic                 rx_perr_pend_reg;
`endif

  assign rx_s     = sync_reg[1];
  assign rx_start = (rx_state_reg == ST_IDLE) && rx_prev_reg && !rx_s;

  // Synchronizer and edge-detect flops reset high so a line held low needs a real fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], bus.RXD};
      rx_prev_reg <= rx_s;
    end
  end

  uart_bitcnt #(.DIV_W(DIV_W)) u_rx_cnt (
    .CLK, .RST, .load(rx_start), .half(1'b1), .period(bus.DIV), .tick(rx_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_reg <= ST_IDLE;
      rx_shift_reg <= '0;
      rx_idx_reg   <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_ferr_reg  <= 1'b0;
      rx_ovr_reg   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_reg      <= 1'b0;
      rx_perr_pend_reg <= 1'b0;
`endif
    end else begin
      // Handshake retires the word; a word completing this same cycle overrides below.
      if (rx_valid_reg && bus.RX_READY) begin
        rx_valid_reg <= 1'b0;
        rx_ovr_reg   <= 1'b0;
      end
      case (rx_state_reg)
        ST_IDLE: if (rx_start) rx_state_reg <= ST_START;
        ST_START: if (rx_tick) begin
          rx_idx_reg   <= '0;
          rx_state_reg <= rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (rx_tick) begin
          rx_shift_reg <= {rx_s, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_idx_reg == LAST_DATA) begin
`ifdef UART_PARITY_EN
            rx_state_reg <= ST_PARITY;
`else
            rx_state_reg <= ST_STOP;
`endif
          end else begin
            rx_idx_reg <= rx_idx_reg + 4'd1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: if (rx_tick) begin
          rx_perr_pend_reg <= rx_s ^ uart_parity(8'(rx_shift_reg), 1'(PARITY_ODD));
          rx_state_reg     <= ST_STOP;
        end
`endif
        ST_STOP: if (rx_tick) begin
          rx_data_reg  <= rx_shift_reg;
          rx_ferr_reg  <= !rx_s;
`ifdef UART_PARITY_EN
          rx_perr_reg  <= rx_perr_pend_reg;
`endif
          rx_valid_reg <= 1'b1;
          if (rx_valid_reg && !bus.RX_READY) rx_ovr_reg <= 1'b1;
          rx_state_reg <= ST_IDLE;
        end
        default: rx_state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.TXD      = txd_reg;
  assign bus.TX_READY = tx_ready_reg;
  assign bus.RX_DATA  = rx_data_reg;
  assign bus.RX_VALID = rx_valid_reg;
  assign bus.RX_FERR  = rx_ferr_reg;
  assign bus.RX_OVR   = rx_ovr_reg;
`ifdef UART_PARITY_EN
  assign bus.RX_PERR  = rx_perr_reg;
`else
  assign bus.RX_PERR  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr: frame-level model of the serial format, directed
// and randomized TX waveforms, loopback, bit-banged RX frames, overrun and reset cases.
module tb_uart_xcvr;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int DIV_W      = 16;
  localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_LEN = 1 + DATA_BITS + PBITS + STOP_BITS;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_xcvr_if #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W)) ifc ();

  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  assign ifc.RXD = loop_en ? ifc.TXD : rxd_drv;

  uart_xcvr #(
    .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .DIV_W(DIV_W), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(ifc)
  );

  int checks   = 0;
  int failures = 0;

  // Received words as {data, ferr, perr, ovr}
  logic [10:0] rx_q[$];
  logic [10:0] exp_q[$];

  always @(negedge CLK) begin
    if (!RST && ifc.RX_VALID && ifc.RX_READY)
      rx_q.push_back({ifc.RX_DATA, ifc.RX_FERR, ifc.RX_PERR, ifc.RX_OVR});
  end

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Line level at bit position idx of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int idx,
                                     input logic stop_val, input logic par_flip);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_BITS) return d[idx-1];
    if (PBITS == 1 && idx == DATA_BITS + 1) return (^d) ^ (PARITY_ODD != 0) ^ par_flip;
    if (idx == DATA_BITS + 1 + PBITS) return stop_val;
    return 1'b1;
  endfunction

  task automatic wait_tx_ready();
    int n = 0;
    @(negedge CLK);
    while (!ifc.TX_READY && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("tx_ready_wait", ifc.TX_READY, 1);
  endtask

  task automatic tx_frame_check(input logic [7:0] d, input logic [15:0] dv,
                                input logic [15:0] dv_after);
    int bad = failures;
    wait_tx_ready();
    ifc.TX_DATA  = d;
    ifc.DIV      = dv;
    ifc.TX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    ifc.TX_VALID = 1'b0;
    ifc.DIV      = dv_after;
    for (int k = 0; k < FRAME_LEN * int'(dv); k++) begin
      @(negedge CLK);
      check("txd_bit", ifc.TXD, frame_bit(d, k / int'(dv), 1'b1, 1'b0));
      check("tx_ready_low", ifc.TX_READY, 0);
    end
    @(negedge CLK);
    check("tx_ready_after", ifc.TX_READY, 1);
    $display("TX frame data=0x%02h div=%0d errors=%0d", d, dv, failures - bad);
  endtask

  task automatic tx_put(input logic [7:0] d, input logic [15:0] dv);
    wait_tx_ready();
    ifc.TX_DATA  = d;
    ifc.DIV      = dv;
    ifc.TX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    ifc.TX_VALID = 1'b0;
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic [15:0] dv,
                          input logic stop_val, input logic par_flip);
    @(posedge CLK);
    #1;
    ifc.DIV = dv;
    for (int i = 0; i < FRAME_LEN; i++) begin
      rxd_drv = frame_bit(d, i, stop_val, par_flip);
      repeat (dv) @(posedge CLK);
      #1;
    end
    rxd_drv = 1'b1;
    repeat (2 * dv) @(posedge CLK);
    #1;
  endtask

  task automatic drain_rx(input string tag);
    int t = 0;
    logic [10:0] e, g;
    while (rx_q.size() < exp_q.size() && t < 20000) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      g = rx_q.pop_front();
      check(tag, g, e);
      $display("RX %s data=0x%02h ferr=%0b perr=%0b ovr=%0b", tag, g[10:3], g[2], g[1], g[0]);
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] dv;
    logic        sb, pf;

    ifc.DIV      = 16'd4;
    ifc.TX_DATA  = '0;
    ifc.TX_VALID = 1'b0;
    ifc.RX_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    @(negedge CLK);
    check("rst_txd", ifc.TXD, 1);
    check("rst_tx_ready", ifc.TX_READY, 1);
    check("rst_rx_valid", ifc.RX_VALID, 0);
    check("rst_rx_data", ifc.RX_DATA, 0);
    check("rst_rx_ferr", ifc.RX_FERR, 0);
    check("rst_rx_perr", ifc.RX_PERR, 0);
    check("rst_rx_ovr", ifc.RX_OVR, 0);
    $display("RESET state checked");

    // TX waveform: 0xA5 at DIV=4, then random words with DIV changed mid-frame
    tx_frame_check(8'hA5, 16'd4, 16'd4);
    for (int r = 0; r < 3; r++) begin
      d  = 8'($urandom_range(0, 255));
      dv = 16'($urandom_range(4, 9));
      tx_frame_check(d, dv, 16'($urandom_range(4, 30)));
    end

    // Loopback, back-to-back words
    loop_en = 1'b1;
    foreach (exp_q[i]) exp_q[i] = '0;
    tx_put(8'h00, 16'd16); exp_q.push_back({8'h00, 3'b000});
    tx_put(8'hFF, 16'd16); exp_q.push_back({8'hFF, 3'b000});
    tx_put(8'h5A, 16'd16); exp_q.push_back({8'h5A, 3'b000});
    drain_rx("loop_fixed");
    for (int r = 0; r < 5; r++) begin
      d  = 8'($urandom_range(0, 255));
      dv = 16'($urandom_range(4, 20));
      tx_put(d, dv);
      exp_q.push_back({d, 3'b000});
    end
    drain_rx("loop_rand");
    loop_en = 1'b0;

    // Start-bit glitch rejected, receiver still usable afterwards
    ifc.DIV = 16'd16;
    @(posedge CLK);
    #1 rxd_drv = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rxd_drv = 1'b1;
    repeat (60) @(posedge CLK);
    #1;
    check("glitch_rx_q", rx_q.size(), 0);
    check("glitch_rx_valid", ifc.RX_VALID, 0);
    rx_drive(8'h96, 16'd16, 1'b1, 1'b0);
    exp_q.push_back({8'h96, 3'b000});
    drain_rx("after_glitch");

    // Framing error then a clean frame
    rx_drive(8'h3C, 16'd8, 1'b0, 1'b0);
    exp_q.push_back({8'h3C, 3'b100});
    rx_drive(8'hC5, 16'd8, 1'b1, 1'b0);
    exp_q.push_back({8'hC5, 3'b000});
    drain_rx("ferr");

    // Overrun: two words with RX_READY low, then one handshake
    ifc.RX_READY = 1'b0;
    rx_drive(8'h11, 16'd8, 1'b1, 1'b0);
    check("ovr_first_valid", ifc.RX_VALID, 1);
    check("ovr_first_data", ifc.RX_DATA, 8'h11);
    check("ovr_first_flag", ifc.RX_OVR, 0);
    rx_drive(8'h22, 16'd8, 1'b1, 1'b0);
    check("ovr_second_valid", ifc.RX_VALID, 1);
    check("ovr_second_data", ifc.RX_DATA, 8'h22);
    check("ovr_second_flag", ifc.RX_OVR, 1);
    ifc.RX_READY = 1'b1;
    exp_q.push_back({8'h22, 3'b001});
    @(negedge CLK);
    @(negedge CLK);
    check("ovr_cleared", ifc.RX_OVR, 0);
    check("ovr_valid_cleared", ifc.RX_VALID, 0);
    drain_rx("ovr");

`ifdef UART_PARITY_EN
    rx_drive(8'h07, 16'd8, 1'b1, 1'b1);
    exp_q.push_back({8'h07, 3'b010});
    rx_drive(8'h07, 16'd8, 1'b1, 1'b0);
    exp_q.push_back({8'h07, 3'b000});
    drain_rx("parity");
`endif

    // Randomized bit-banged frames with occasional bad stop / parity bits
    for (int r = 0; r < 10; r++) begin
      d  = 8'($urandom_range(0, 255));
      dv = 16'($urandom_range(4, 24));
      sb = ($urandom_range(0, 3) != 0);
      pf = (PBITS == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      rx_drive(d, dv, sb, pf);
      exp_q.push_back({d, !sb, pf, 1'b0});
    end
    drain_rx("rx_rand");

    // Reset in the middle of a loopback frame
    loop_en = 1'b1;
    tx_put(8'h00, 16'd16);
    repeat (30) @(negedge CLK);
    check("mid_frame_txd", ifc.TXD, 0);
    #1 RST = 1'b1;
    #1;
    check("async_rst_txd", ifc.TXD, 1);
    check("async_rst_tx_ready", ifc.TX_READY, 1);
    check("async_rst_rx_valid", ifc.RX_VALID, 0);
    #1 RST = 1'b0;
    repeat (300) @(negedge CLK);
    check("post_rst_no_word", rx_q.size(), 0);
    tx_put(8'hC3, 16'd16);
    exp_q.push_back({8'hC3, 3'b000});
    drain_rx("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
